qick_arith_issue: RTL and testbench

- Issue/writeback stage between the processor decode stage and the two multicycle arithmetic units: the pipelined divider and the DSP multiply-add unit.
- Accepts one command at a time per unit over a valid/ready handshake and pulses that unit's start.
- Waits out the unit's busy window, captures its result into holding registers and raises a result-valid flag for the core to read.
- Arith and div paths run concurrently and independently.

---
 rtl/qick_arith_issue_if.sv | 22 ++
 rtl/qick_arith_issue.sv | 202 ++++++++++++++++++++
 tb/tb_qick_arith_issue.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/qick_arith_issue_if.sv
// Command bus from the decode stage into the arithmetic issue stage.
interface qick_arith_issue_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_unit;    // 0 = arith (DSP multiply-add), 1 = divider
  logic        cmd_signed;  // divider only: two's complement operands
  logic [4:0]  cmd_op;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic [31:0] cmd_c;
  logic [31:0] cmd_d;

  modport master (
    output cmd_valid, cmd_unit, cmd_signed, cmd_op, cmd_a, cmd_b, cmd_c, cmd_d,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_unit, cmd_signed, cmd_op, cmd_a, cmd_b, cmd_c, cmd_d,
    output cmd_ready
  );
endinterface

// File: rtl/qick_arith_issue.sv
// Issue/writeback stage for the pipelined divider and the DSP multiply-add
// unit. Each path: IDLE -> LAUNCH (start pulse) -> SKIP -> WAIT -> IDLE,
// with a per-path timeout that raises a sticky error.
module qick_arith_issue #(
  parameter int unsigned DIV_TMO   = 40,
  parameter int unsigned ARITH_TMO = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  qick_arith_issue_if.slave    cmd,
  output logic                 arith_start_o,
  output logic [31:0]          arith_a_o,
  output logic [31:0]          arith_b_o,
  output logic [31:0]          arith_c_o,
  output logic [31:0]          arith_d_o,
  output logic [4:0]           arith_op_o,
  input  logic                 arith_ready_i,
  input  logic [63:0]          arith_res_i,
  output logic                 div_start_o,
  output logic [31:0]          div_a_o,
  output logic [31:0]          div_b_o,
  input  logic                 div_ready_i,
  input  logic [31:0]          div_q_i,
  input  logic [31:0]          div_r_i,
  output logic [63:0]          arith_res_o,
  output logic                 arith_vld_o,
  output logic [31:0]          div_q_o,
  output logic [31:0]          div_r_o,
  output logic                 div_vld_o,
  output logic                 div_dz_o,
  output logic                 err_o,
  output logic                 busy_o
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LAUNCH = 2'd1;
  localparam logic [1:0] SKIP   = 2'd2;
  localparam logic [1:0] WAIT   = 2'd3;

  localparam int unsigned CW = 16;

  logic [1:0]    a_st_q, d_st_q;
  logic [CW-1:0] a_cnt_q, d_cnt_q;
  logic          a_acc, d_acc, a_tmo, d_tmo;

  logic [31:0]   a_a_q, a_b_q, a_c_q, a_d_q;
  logic [4:0]    a_op_q;
  logic [63:0]   a_res_q;
  logic          a_vld_q;

  logic [31:0]   d_a_q, d_b_q, d_q_q, d_r_q;
  logic          d_sa_q, d_sb_q, d_zero_q, d_vld_q, d_dz_q, err_q;
  logic [31:0]   d_abs_a, d_abs_b, d_raw_a;

  // Command acceptance: ready reflects only the addressed path's FSM.
  assign cmd.cmd_ready = rst_ni & (cmd.cmd_unit ? (d_st_q == IDLE) : (a_st_q == IDLE));
  assign a_acc = cmd.cmd_valid & cmd.cmd_ready & ~cmd.cmd_unit;
  assign d_acc = cmd.cmd_valid & cmd.cmd_ready &  cmd.cmd_unit;

  // Timeout checks: ready_i takes precedence on the deciding cycle.
  assign a_tmo = (a_st_q == WAIT) & ~arith_ready_i & (a_cnt_q >= CW'(ARITH_TMO));
  assign d_tmo = (d_st_q == WAIT) & ~div_ready_i   & (d_cnt_q >= CW'(DIV_TMO));

  // Divider is unsigned; send magnitudes. -(-2^31) wraps back to 0x80000000.
  assign d_abs_a = (cmd.cmd_signed & cmd.cmd_a[31]) ? (32'd0 - cmd.cmd_a) : cmd.cmd_a;
  assign d_abs_b = (cmd.cmd_signed & cmd.cmd_b[31]) ? (32'd0 - cmd.cmd_b) : cmd.cmd_b;
  // Raw dividend for the divide-by-zero result is recovered from the magnitude.
  assign d_raw_a = d_sa_q ? (32'd0 - d_a_q) : d_a_q;

  // Arith path FSM, operand and result registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_st_q  <= IDLE;
      a_cnt_q <= '0;
      a_a_q   <= '0;
      a_b_q   <= '0;
      a_c_q   <= '0;
      a_d_q   <= '0;
      a_op_q  <= '0;
      a_res_q <= '0;
      a_vld_q <= 1'b0;
    end else begin
      case (a_st_q)
        IDLE: if (a_acc) begin
          a_st_q  <= LAUNCH;
          a_cnt_q <= CW'(1);
          a_a_q   <= cmd.cmd_a;
          a_b_q   <= cmd.cmd_b;
          a_c_q   <= cmd.cmd_c;
          a_d_q   <= cmd.cmd_d;
          a_op_q  <= cmd.cmd_op;
          a_vld_q <= 1'b0;
        end
        LAUNCH: begin
          a_st_q  <= SKIP;
          a_cnt_q <= a_cnt_q + CW'(1);
        end
        SKIP: begin
          a_st_q  <= WAIT;
          a_cnt_q <= a_cnt_q + CW'(1);
        end
        default: begin
          if (arith_ready_i) begin
            a_res_q <= arith_res_i;
            a_vld_q <= 1'b1;
            a_st_q  <= IDLE;
          end else if (a_tmo) begin
            a_st_q  <= IDLE;
          end else begin
            a_cnt_q <= a_cnt_q + CW'(1);
          end
        end
      endcase
    end
  end

  // Div path FSM; a zero divisor resolves in LAUNCH without starting the unit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      d_st_q   <= IDLE;
      d_cnt_q  <= '0;
      d_a_q    <= '0;
      d_b_q    <= '0;
      d_sa_q   <= 1'b0;
      d_sb_q   <= 1'b0;
      d_zero_q <= 1'b0;
      d_q_q    <= '0;
      d_r_q    <= '0;
      d_vld_q  <= 1'b0;
      d_dz_q   <= 1'b0;
    end else begin
      case (d_st_q)
        IDLE: if (d_acc) begin
          d_st_q   <= LAUNCH;
          d_cnt_q  <= CW'(1);
          d_a_q    <= d_abs_a;
          d_b_q    <= d_abs_b;
          d_sa_q   <= cmd.cmd_signed & cmd.cmd_a[31];
          d_sb_q   <= cmd.cmd_signed & cmd.cmd_b[31];
          d_zero_q <= (cmd.cmd_b == 32'd0);
          d_vld_q  <= 1'b0;
          d_dz_q   <= 1'b0;
        end
        LAUNCH: begin
          if (d_zero_q) begin
            d_q_q   <= '1;
            d_r_q   <= d_raw_a;
            d_dz_q  <= 1'b1;
            d_vld_q <= 1'b1;
            d_st_q  <= IDLE;
          end else begin
            d_st_q  <= SKIP;
            d_cnt_q <= d_cnt_q + CW'(1);
          end
        end
        SKIP: begin
          d_st_q  <= WAIT;
          d_cnt_q <= d_cnt_q + CW'(1);
        end
        default: begin
          if (div_ready_i) begin
            d_q_q   <= (d_sa_q ^ d_sb_q) ? (32'd0 - div_q_i) : div_q_i;
            d_r_q   <= d_sa_q ? (32'd0 - div_r_i) : div_r_i;
            d_vld_q <= 1'b1;
            d_st_q  <= IDLE;
          end else if (d_tmo) begin
            d_st_q  <= IDLE;
          end else begin
            d_cnt_q <= d_cnt_q + CW'(1);
          end
        end
      endcase
    end
  end

  // Sticky timeout error from either path.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)             err_q <= 1'b0;
    else if (a_tmo || d_tmo) err_q <= 1'b1;
  end

  assign arith_start_o = (a_st_q == LAUNCH);
  assign arith_a_o     = a_a_q;
  assign arith_b_o     = a_b_q;
  assign arith_c_o     = a_c_q;
  assign arith_d_o     = a_d_q;
  assign arith_op_o    = a_op_q;
  assign arith_res_o   = a_res_q;
  assign arith_vld_o   = a_vld_q;

  assign div_start_o   = (d_st_q == LAUNCH) & ~d_zero_q;
  assign div_a_o       = d_a_q;
  assign div_b_o       = d_b_q;
  assign div_q_o       = d_q_q;
  assign div_r_o       = d_r_q;
  assign div_vld_o     = d_vld_q;
  assign div_dz_o      = d_dz_q;

  assign err_o         = err_q;
  assign busy_o        = (a_st_q != IDLE) | (d_st_q != IDLE);

endmodule

// File: tb/tb_qick_arith_issue.sv
// Directed bench for qick_arith_issue: div (unsigned/signed/zero), concurrent
// arith+div, arith timeout and reset mid-operation.
module tb_qick_arith_issue;
  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        arith_start_o, arith_ready_i, arith_vld_o;
  logic [31:0] arith_a_o, arith_b_o, arith_c_o, arith_d_o;
  logic [4:0]  arith_op_o;
  logic [63:0] arith_res_i, arith_res_o;
  logic        div_start_o, div_ready_i, div_vld_o, div_dz_o, err_o, busy_o;
  logic [31:0] div_a_o, div_b_o, div_q_i, div_r_i, div_q_o, div_r_o;

  int n_cmp = 0;
  int n_bad = 0;
  int n_start;

  qick_arith_issue_if cmd_if ();

  qick_arith_issue #(.DIV_TMO(40), .ARITH_TMO(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .cmd(cmd_if),
    .arith_start_o(arith_start_o), .arith_a_o(arith_a_o), .arith_b_o(arith_b_o),
    .arith_c_o(arith_c_o), .arith_d_o(arith_d_o), .arith_op_o(arith_op_o),
    .arith_ready_i(arith_ready_i), .arith_res_i(arith_res_i),
    .div_start_o(div_start_o), .div_a_o(div_a_o), .div_b_o(div_b_o),
    .div_ready_i(div_ready_i), .div_q_i(div_q_i), .div_r_i(div_r_i),
    .arith_res_o(arith_res_o), .arith_vld_o(arith_vld_o),
    .div_q_o(div_q_o), .div_r_o(div_r_o), .div_vld_o(div_vld_o),
    .div_dz_o(div_dz_o), .err_o(err_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue(input logic unit, input logic sgn, input logic [4:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [31:0] d);
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_unit   = unit;
    cmd_if.cmd_signed = sgn;
    cmd_if.cmd_op     = op;
    cmd_if.cmd_a      = a;
    cmd_if.cmd_b      = b;
    cmd_if.cmd_c      = c;
    cmd_if.cmd_d      = d;
    #1;
  endtask

  initial begin
    rst_ni = 1'b0;
    cmd_if.cmd_valid = 1'b0; cmd_if.cmd_unit = 1'b0; cmd_if.cmd_signed = 1'b0;
    cmd_if.cmd_op = '0; cmd_if.cmd_a = '0; cmd_if.cmd_b = '0;
    cmd_if.cmd_c = '0; cmd_if.cmd_d = '0;
    arith_ready_i = 1'b1; arith_res_i = '0;
    div_ready_i = 1'b1; div_q_i = '0; div_r_i = '0;

    // Reset state
    step(); step();
    chk("rst_ready", cmd_if.cmd_ready, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_vld", {arith_vld_o, div_vld_o, div_dz_o}, 0);
    rst_ni = 1'b1;
    #1;
    chk("post_rst_ready", cmd_if.cmd_ready, 1);

    // Unsigned div 100/7, divider ready 34 cycles after start
    issue(1'b1, 1'b0, 5'd0, 32'd100, 32'd7, 32'd0, 32'd0);
    chk("u_ready", cmd_if.cmd_ready, 1);
    step(); cmd_if.cmd_valid = 1'b0;
    chk("u_start", div_start_o, 1);
    chk("u_ops", {div_a_o, div_b_o}, {32'd100, 32'd7});
    step(); div_ready_i = 1'b0;
    n_start = 0;
    for (int i = 0; i < 33; i++) begin
      step();
      if (div_start_o) n_start++;
    end
    chk("u_single_start", n_start, 0);
    chk("u_vld_pending", div_vld_o, 0);
    div_ready_i = 1'b1; div_q_i = 32'd14; div_r_i = 32'd2;
    step();
    chk("u_qr", {div_q_o, div_r_o}, {32'd14, 32'd2});
    chk("u_flags", {div_vld_o, div_dz_o, busy_o, err_o}, 4'b1000);

    // Signed div -100/7
    issue(1'b1, 1'b1, 5'd0, 32'hFFFF_FF9C, 32'd7, 32'd0, 32'd0);
    step(); cmd_if.cmd_valid = 1'b0;
    chk("s_ops", {div_a_o, div_b_o}, {32'd100, 32'd7});
    chk("s_vld_clr", div_vld_o, 0);
    step(); div_ready_i = 1'b0;
    step(); step();
    div_ready_i = 1'b1; div_q_i = 32'd14; div_r_i = 32'd2;
    step();
    chk("s_qr", {div_q_o, div_r_o}, {32'hFFFF_FFF2, 32'hFFFF_FFFE});
    chk("s_vld", div_vld_o, 1);

    // Divide by zero, unsigned
    issue(1'b1, 1'b0, 5'd0, 32'h1234, 32'd0, 32'd0, 32'd0);
    step(); cmd_if.cmd_valid = 1'b0;
    chk("dz_nostart", {div_start_o, div_vld_o, div_dz_o}, 0);
    step();
    chk("dz_qr", {div_q_o, div_r_o}, {32'hFFFF_FFFF, 32'h1234});
    chk("dz_flags", {div_vld_o, div_dz_o, busy_o, div_start_o}, 4'b1100);

    // Divide by zero, signed negative dividend returns raw a
    issue(1'b1, 1'b1, 5'd0, 32'hFFFF_FFFB, 32'd0, 32'd0, 32'd0);
    step(); cmd_if.cmd_valid = 1'b0;
    chk("dzs_nostart", div_start_o, 0);
    step();
    chk("dzs_qr", {div_q_o, div_r_o}, {32'hFFFF_FFFF, 32'hFFFF_FFFB});

    // Concurrent: div then arith 3*5
    issue(1'b1, 1'b0, 5'd0, 32'd100, 32'd7, 32'd0, 32'd0);
    step();
    chk("c_dz_clr", {div_dz_o, div_vld_o}, 0);
    div_ready_i = 1'b0;
    issue(1'b0, 1'b0, 5'd0, 32'd3, 32'd5, 32'd0, 32'd7);
    chk("c_arith_ready", cmd_if.cmd_ready, 1);
    step(); cmd_if.cmd_valid = 1'b0;
    chk("c_arith_start", arith_start_o, 1);
    chk("c_arith_ops", {arith_a_o, arith_b_o, arith_d_o, 27'd0, arith_op_o},
        {32'd3, 32'd5, 32'd7, 32'd0});
    step(); arith_ready_i = 1'b0;
    step(); step();
    arith_ready_i = 1'b1; arith_res_i = 64'd15;
    step();
    chk("c_arith_res", arith_res_o, 64'd15);
    chk("c_flags", {arith_vld_o, div_vld_o, busy_o}, 3'b101);
    issue(1'b1, 1'b0, 5'd0, 32'd50, 32'd5, 32'd0, 32'd0);
    chk("c_div_blocked", cmd_if.cmd_ready, 0);
    step();
    chk("c_div_blocked2", {cmd_if.cmd_ready, div_start_o}, 0);
    div_ready_i = 1'b1; div_q_i = 32'd14; div_r_i = 32'd2;
    step();
    chk("c_div1_q", {div_q_o, div_r_o, 31'd0, div_vld_o}, {32'd14, 32'd2, 32'd1});
    chk("c_div_ready", cmd_if.cmd_ready, 1);
    step(); cmd_if.cmd_valid = 1'b0;
    chk("c_div2_start", {div_start_o, div_vld_o}, 2'b10);
    chk("c_div2_a", div_a_o, 32'd50);
    step(); div_ready_i = 1'b0;
    step();
    div_ready_i = 1'b1; div_q_i = 32'd10; div_r_i = 32'd0;
    step();
    chk("c_div2_q", {div_q_o, div_r_o, 31'd0, div_vld_o}, {32'd10, 32'd0, 32'd1});

    // Arith timeout
    arith_ready_i = 1'b0;
    issue(1'b0, 1'b0, 5'd3, 32'd1, 32'd1, 32'd0, 32'd0);
    step(); cmd_if.cmd_valid = 1'b0;
    repeat (7) step();
    chk("t_before", {err_o, busy_o}, 2'b01);
    step();
    chk("t_after", {err_o, busy_o, arith_vld_o}, 3'b100);
    chk("t_res_hold", arith_res_o, 64'd15);
    issue(1'b0, 1'b0, 5'd1, 32'd2, 32'd0, 32'd0, 32'd0);
    chk("t_next_ready", cmd_if.cmd_ready, 1);
    step(); cmd_if.cmd_valid = 1'b0;
    chk("t_next_start", {arith_start_o, arith_op_o}, {1'b1, 5'd1});
    step(); step();
    arith_ready_i = 1'b1; arith_res_i = 64'h1_0000_0002;
    step();
    chk("t_next_res", {arith_res_o, 6'd0, arith_vld_o, err_o}, {64'h1_0000_0002, 8'h03});

    // Reset in the middle of a div
    issue(1'b1, 1'b0, 5'd0, 32'd9, 32'd3, 32'd0, 32'd0);
    step(); cmd_if.cmd_valid = 1'b0;
    step(); div_ready_i = 1'b0;
    step(); step();
    chk("r_busy", busy_o, 1);
    rst_ni = 1'b0;
    #1;
    chk("r_flags", {err_o, busy_o, arith_vld_o, div_vld_o, div_dz_o, cmd_if.cmd_ready}, 0);
    chk("r_data", {arith_res_o, div_q_o}, 0);
    chk("r_ops", {div_a_o, arith_a_o}, 0);
    div_ready_i = 1'b1; div_q_i = 32'd3;
    step();
    rst_ni = 1'b1;
    cmd_if.cmd_unit = 1'b1;
    #1;
    chk("r_ready", cmd_if.cmd_ready, 1);
    step(); step();
    chk("r_late_ready", {div_vld_o, busy_o, div_start_o}, 0);
    chk("r_late_q", div_q_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
